pair_batch_generator: RTL and testbench
=======================================

PAIR_BATCH_GENERATOR -- requirements
Module: pair_batch_generator

Interface
REQ-001 SHALL have parameter MAX_NODE_COUNT, default 2000, maximum points stored.
REQ-002 SHALL have parameter COORD_BIT_WIDTH, default 12, bits per coordinate.
REQ-003 SHALL have parameter DIMENSIONS, default 3, coordinates per point.
REQ-004 SHALL have parameter BATCH_SIZE, default 16, lanes per output batch; localparam INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT).
REQ-005 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst  input  1  synchronous active-high reset.
REQ-007 SHALL have port pt_valid  input  1  load point offered.
REQ-008 SHALL have port pt_ready  output  1  load point accepted when pt_valid && pt_ready.
REQ-009 SHALL have port pt_coords  input  [COORD_BIT_WIDTH-1:0] x DIMENSIONS  point coordinates.
REQ-010 SHALL have port pt_last  input  1  marks final point of the load stream.
REQ-011 SHALL have port batch_coords  output  [COORD_BIT_WIDTH-1:0] x BATCH_SIZE x DIMENSIONS  lane coordinates.
REQ-012 SHALL have port batch_indices  output  [INDEX_BIT_WIDTH-1:0] x BATCH_SIZE  lane point index.
REQ-013 SHALL have port batch_valid  output  BATCH_SIZE  per-lane valid; batch offered iff nonzero.
REQ-014 SHALL have port batch_line_end  output  1  batch is last of current reference line.
REQ-015 SHALL have port batch_stream_end  output  1  batch is last of whole stream.
REQ-016 SHALL have port out_ready  input  1  consumer accepts batch when |batch_valid && out_ready.
REQ-017 SHALL have ports done  output  1 (enumeration complete) and overflow  output  1 (sticky, point dropped).

Function
REQ-018 SHALL implement states LOAD, EMIT, DONE; LOAD->EMIT on accepted point with pt_last; EMIT->DONE on accepted batch with batch_stream_end; DONE held until rst.
REQ-019 In LOAD, pt_ready SHALL be 1; each accepted point SHALL be stored at index n (count of stored points), n increments.
REQ-020 A point accepted when n == MAX_NODE_COUNT SHALL be discarded, overflow set to 1; pt_last still honoured.
REQ-021 In EMIT, reference i runs 0..n-1; line i SHALL cover points j = i..n-1 in batches of base b = i, i+BATCH_SIZE, ...; lane k carries point b+k, valid iff b+k < n.
REQ-022 Lane 0 of first batch of each line SHALL be the reference point i itself (index i).
REQ-023 batch_line_end SHALL be 1 iff b+BATCH_SIZE >= n; batch_stream_end SHALL be 1 iff batch_line_end && i == n-1; both 0 when batch_valid == 0.
REQ-024 Batch outputs SHALL be driven from registered state only and SHALL stay stable while offered and out_ready == 0.
REQ-025 On accept: if not line_end, b += BATCH_SIZE; else i += 1, b = i+1; no bubble between batches while out_ready == 1 (one batch per cycle).
REQ-026 First batch SHALL be offered the cycle after the pt_last accept; total batches = sum over i of ceil((n-i)/BATCH_SIZE).
REQ-027 In EMIT and DONE pt_ready SHALL be 0; done SHALL be 1 only in DONE.
REQ-028 Index arithmetic SHALL use INDEX_BIT_WIDTH+1 bits internally so b+k comparisons never wrap.

Reset
REQ-029 rst SHALL force state LOAD, n = 0, i = 0, b = 0, overflow = 0, done = 0, batch_valid = 0, batch_line_end = 0, batch_stream_end = 0, pt_ready = 1 on the following cycle.
REQ-030 rst asserted mid-LOAD or mid-EMIT SHALL abandon all stored points; no batch SHALL be offered until a new load completes.

Configuration
REQ-031 With macro PAIR_BATCH_STATS_EN defined, SHALL add output batch_count [31:0], reset 0, incremented per accepted batch, holding final count in DONE.
REQ-032 Without PAIR_BATCH_STATS_EN, batch_count port and counter SHALL not exist; all other behaviour identical.

Verification
REQ-033 Load 1 point (pt_last on it) -> single batch, batch_valid = 16'h0001, index 0, line_end = 1, stream_end = 1, then done = 1.
REQ-034 Load 20 points, out_ready = 1 -> 24 batches back-to-back; line 0 batch 1 valid 16'hFFFF, batch 2 valid 16'h000F with line_end; final batch index 19 lane 0, stream_end.
REQ-035 Load 17 points, toggle out_ready every other cycle -> outputs stable while stalled; 17+... exact 18 batches (line 0: 2, lines 1..16: 1), none duplicated or skipped.
REQ-036 Load MAX_NODE_COUNT+2 points -> overflow = 1, n = MAX_NODE_COUNT, enumeration still completes correctly.
REQ-037 Assert rst during EMIT after 5 batches -> batch_valid = 0, pt_ready = 1 next cycle; reload 3 points -> 3 batches, valids 16'h0007, 16'h0003, 16'h0001.
REQ-038 With PAIR_BATCH_STATS_EN, 20-point load -> batch_count = 24 in DONE.

Source files
------------

// File: rtl/pair_batch_generator.sv
// Loads a stream of points, then enumerates every (i, j >= i) pair as BATCH_SIZE-wide batches.
// Optional feature: define PAIR_BATCH_STATS_EN to add the batch_count accepted-batch counter.
module pair_batch_generator #(
    parameter int MAX_NODE_COUNT  = 2000,
    parameter int COORD_BIT_WIDTH = 12,
    parameter int DIMENSIONS      = 3,
    parameter int BATCH_SIZE      = 16,
    localparam int INDEX_BIT_WIDTH = $clog2(MAX_NODE_COUNT)
) (
    input  logic                                                        clk,
    input  logic                                                        rst,
    input  logic                                                        pt_valid,
    output logic                                                        pt_ready,
    input  logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]                  pt_coords,
    input  logic                                                        pt_last,
    output logic [BATCH_SIZE-1:0][DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0]  batch_coords,
    output logic [BATCH_SIZE-1:0][INDEX_BIT_WIDTH-1:0]                  batch_indices,
    output logic [BATCH_SIZE-1:0]                                       batch_valid,
    output logic                                                        batch_line_end,
    output logic                                                        batch_stream_end,
    input  logic                                                        out_ready,
`ifdef PAIR_BATCH_STATS_EN
    output logic [31:0]                                                 batch_count,
`endif
    output logic                                                        done,
    output logic                                                        overflow
);

    // One spare bit keeps base + lane offsets from wrapping past the stored range.
    localparam int IW = INDEX_BIT_WIDTH + 1;
    localparam logic [IW-1:0] BATCH_STEP = IW'(BATCH_SIZE);
    localparam logic [IW-1:0] NODE_LIMIT = IW'(MAX_NODE_COUNT);

    typedef enum logic [1:0] {LOAD, EMIT, DONE} state_t;

    state_t state, state_next;

    logic [IW-1:0] node_count;
    logic [IW-1:0] ref_idx;
    logic [IW-1:0] base_idx;
    logic [IW-1:0] lane_idx [BATCH_SIZE];

    logic [DIMENSIONS-1:0][COORD_BIT_WIDTH-1:0] point_mem [MAX_NODE_COUNT];

    logic pt_accept;
    logic batch_accept;
    logic has_room;
    logic line_end;
    logic stream_end;

    assign pt_ready     = (state == LOAD);
    assign done         = (state == DONE);
    assign pt_accept    = pt_valid && pt_ready;
    assign batch_accept = (|batch_valid) && out_ready;
    assign has_room     = (node_count < NODE_LIMIT);
    assign line_end     = ((base_idx + BATCH_STEP) >= node_count);
    assign stream_end   = line_end && ((ref_idx + IW'(1)) == node_count);

    assign batch_line_end   = (|batch_valid) && line_end;
    assign batch_stream_end = (|batch_valid) && stream_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            LOAD:    if (pt_accept && pt_last) state_next = EMIT;
            EMIT:    if (batch_accept && stream_end) state_next = DONE;
            DONE:    state_next = DONE;
            default: state_next = LOAD;
        endcase
    end

    // Reference/base walk: step the base within a line, then restart at the next reference.
    always_ff @(posedge clk) begin
        if (rst) begin
            node_count <= '0;
            ref_idx    <= '0;
            base_idx   <= '0;
            overflow   <= 1'b0;
        end else begin
            if (pt_accept) begin
                if (has_room) begin
                    node_count <= node_count + IW'(1);
                end else begin
                    overflow <= 1'b1;
                end
            end
            if (batch_accept) begin
                if (!line_end) begin
                    base_idx <= base_idx + BATCH_STEP;
                end else begin
                    ref_idx  <= ref_idx + IW'(1);
                    base_idx <= ref_idx + IW'(1);
                end
            end
        end
    end

    // Point storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clk) begin
        if (pt_accept && has_room) begin
            point_mem[node_count[INDEX_BIT_WIDTH-1:0]] <= pt_coords;
        end
    end

    for (genvar k = 0; k < BATCH_SIZE; k++) begin : g_lane
        assign lane_idx[k] = base_idx + IW'(k);
    end

    always_comb begin
        batch_valid   = '0;
        batch_indices = '0;
        batch_coords  = '0;
        for (int k = 0; k < BATCH_SIZE; k++) begin
            if ((state == EMIT) && (lane_idx[k] < node_count)) begin
                batch_valid[k]   = 1'b1;
                batch_indices[k] = lane_idx[k][INDEX_BIT_WIDTH-1:0];
                batch_coords[k]  = point_mem[lane_idx[k][INDEX_BIT_WIDTH-1:0]];
            end
        end
    end

`ifdef PAIR_BATCH_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            batch_count <= '0;
        end else if (batch_accept) begin
            batch_count <= batch_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pair_batch_generator.sv
// Randomized self-checking bench for pair_batch_generator; expected batches come from a
// pair-enumeration model built directly from the stored point list.
module tb_pair_batch_generator;

    localparam int MAX_NODES = 24;
    localparam int CW        = 12;
    localparam int DIMS      = 3;
    localparam int BS        = 16;
    localparam int IDXW      = $clog2(MAX_NODES);

    typedef logic [DIMS-1:0][CW-1:0] point_t;

    typedef struct {
        logic [BS-1:0] valid;
        int            base;
        logic          line_end;
        logic          stream_end;
    } batch_t;

    logic                               clk;
    logic                               rst;
    logic                               pt_valid;
    logic                               pt_ready;
    point_t                             pt_coords;
    logic                               pt_last;
    logic [BS-1:0][DIMS-1:0][CW-1:0]    batch_coords;
    logic [BS-1:0][IDXW-1:0]            batch_indices;
    logic [BS-1:0]                      batch_valid;
    logic                               batch_line_end;
    logic                               batch_stream_end;
    logic                               out_ready;
    logic                               done;
    logic                               overflow;
`ifdef PAIR_BATCH_STATS_EN
    logic [31:0]                        batch_count;
`endif

    int checks = 0;
    int errors = 0;

    point_t ref_pts[$];
    batch_t exp_q[$];

    pair_batch_generator #(
        .MAX_NODE_COUNT (MAX_NODES),
        .COORD_BIT_WIDTH(CW),
        .DIMENSIONS     (DIMS),
        .BATCH_SIZE     (BS)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pt_valid        (pt_valid),
        .pt_ready        (pt_ready),
        .pt_coords       (pt_coords),
        .pt_last         (pt_last),
        .batch_coords    (batch_coords),
        .batch_indices   (batch_indices),
        .batch_valid     (batch_valid),
        .batch_line_end  (batch_line_end),
        .batch_stream_end(batch_stream_end),
        .out_ready       (out_ready),
`ifdef PAIR_BATCH_STATS_EN
        .batch_count     (batch_count),
`endif
        .done            (done),
        .overflow        (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every reference i pairs with j = i..n-1, chopped into BS-wide batches.
    function automatic void build_expected();
        int n;
        n = ref_pts.size();
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            for (int b = i; b < n; b += BS) begin
                batch_t e;
                e.valid = '0;
                for (int k = 0; k < BS; k++) begin
                    if (b + k < n) e.valid[k] = 1'b1;
                end
                e.base       = b;
                e.line_end   = (b + BS >= n);
                e.stream_end = e.line_end && (i == n - 1);
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        pt_valid  = 1'b0;
        pt_last   = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Starts and ends on a falling edge; the first batch should be visible on return.
    task automatic load_points(input int count);
        ref_pts.delete();
        for (int p = 0; p < count; p++) begin
            point_t pt;
            if (p > 0) @(negedge clk);
            checks++;
            if (pt_ready !== 1'b1) begin
                errors++;
                $display("[TB] FAIL load_ready point %0d: pt_ready=%b required 1", p, pt_ready);
            end
            for (int d = 0; d < DIMS; d++) pt[d] = CW'($urandom);
            pt_coords = pt;
            pt_valid  = 1'b1;
            pt_last   = (p == count - 1);
            if (ref_pts.size() < MAX_NODES) ref_pts.push_back(pt);
        end
        @(negedge clk);
        pt_valid = 1'b0;
        pt_last  = 1'b0;
        build_expected();
    endtask

    task automatic collect(input bit toggle, input int stop_after, output int accepted, output int cycles);
        int     idx;
        int     limit;
        bit     r;
        bit     lane_bad;
        batch_t e;
        idx    = 0;
        cycles = 0;
        limit  = 4 * exp_q.size() + 20;
        while (idx < exp_q.size() && idx < stop_after && cycles < limit) begin
            e = exp_q[idx];
            checks++;
            if (batch_valid === '0) begin
                errors++;
                $display("[TB] FAIL bubble at batch %0d: batch_valid=%h required %h", idx, batch_valid, e.valid);
            end else begin
                checks++;
                if (batch_valid !== e.valid) begin
                    errors++;
                    $display("[TB] FAIL valid batch %0d: got %h required %h", idx, batch_valid, e.valid);
                end
                checks++;
                if ({batch_line_end, batch_stream_end} !== {e.line_end, e.stream_end}) begin
                    errors++;
                    $display("[TB] FAIL flags batch %0d: line/stream got %b%b required %b%b",
                             idx, batch_line_end, batch_stream_end, e.line_end, e.stream_end);
                end
                lane_bad = 1'b0;
                for (int k = 0; k < BS; k++) begin
                    if (e.valid[k]) begin
                        if (batch_indices[k] !== IDXW'(e.base + k) || batch_coords[k] !== ref_pts[e.base + k])
                            lane_bad = 1'b1;
                    end
                end
                checks++;
                if (lane_bad) begin
                    errors++;
                    $display("[TB] FAIL lanes batch %0d: lane0 index got %0d required %0d",
                             idx, batch_indices[0], e.base);
                end
            end
            r = toggle ? ((cycles % 2) == 1) : 1'b1;
            out_ready = r;
            if (r && batch_valid !== '0) idx++;
            @(negedge clk);
            cycles++;
        end
        out_ready = 1'b0;
        accepted  = idx;
    endtask

    task automatic check_finished(input string name, input int acc, input int want);
        checks++;
        if (acc != want) begin
            errors++;
            $display("[TB] FAIL %s count: accepted %0d batches required %0d", name, acc, want);
        end
        checks++;
        if (done !== 1'b1 || batch_valid !== '0 || pt_ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s end: done=%b valid=%h pt_ready=%b required 1/0/0",
                     name, done, batch_valid, pt_ready);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pt_ready !== 1'b1 || batch_valid !== '0 || done !== 1'b0 || overflow !== 1'b0 ||
            batch_line_end !== 1'b0 || batch_stream_end !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_state: ready=%b valid=%h done=%b ovf=%b le=%b se=%b required 1/0/0/0/0/0",
                     pt_ready, batch_valid, done, overflow, batch_line_end, batch_stream_end);
        end
    endtask

    task automatic test_single_point();
        int acc, cyc;
        do_reset();
        load_points(1);
        checks++;
        if (batch_valid !== 16'h0001 || batch_line_end !== 1'b1 || batch_stream_end !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_first: valid=%h le=%b se=%b required 0001/1/1",
                     batch_valid, batch_line_end, batch_stream_end);
        end
        collect(1'b0, 1000, acc, cyc);
        check_finished("single", acc, 1);
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL single_done_hold: done=%b required 1", done);
        end
    endtask

    task automatic test_back_to_back();
        int acc, cyc;
        do_reset();
        load_points(20);
        collect(1'b0, 1000, acc, cyc);
        check_finished("back_to_back", acc, 24);
        checks++;
        if (cyc != 24) begin
            errors++;
            $display("[TB] FAIL back_to_back_cycles: took %0d cycles required 24", cyc);
        end
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL back_to_back_overflow: overflow=%b required 0", overflow);
        end
`ifdef PAIR_BATCH_STATS_EN
        checks++;
        if (batch_count !== 32'd24) begin
            errors++;
            $display("[TB] FAIL batch_count: got %0d required 24", batch_count);
        end
`endif
    endtask

    task automatic test_stall();
        int acc, cyc;
        do_reset();
        load_points(17);
        collect(1'b1, 1000, acc, cyc);
        check_finished("stall", acc, 18);
    endtask

    task automatic test_overflow();
        int acc, cyc;
        do_reset();
        load_points(MAX_NODES + 2);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_flag: overflow=%b required 1", overflow);
        end
        collect(1'b0, 1000, acc, cyc);
        check_finished("overflow", acc, exp_q.size());
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overflow_sticky: overflow=%b required 1", overflow);
        end
    endtask

    task automatic test_reset_mid_emit();
        int acc, cyc;
        do_reset();
        load_points(20);
        collect(1'b0, 5, acc, cyc);
        checks++;
        if (acc != 5) begin
            errors++;
            $display("[TB] FAIL mid_emit_progress: accepted %0d required 5", acc);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (batch_valid !== '0 || pt_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_emit_reset: valid=%h ready=%b done=%b required 0/1/0",
                     batch_valid, pt_ready, done);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (batch_valid !== '0) begin
            errors++;
            $display("[TB] FAIL mid_emit_idle: valid=%h required 0", batch_valid);
        end
        load_points(3);
        collect(1'b0, 1000, acc, cyc);
        check_finished("reload", acc, 3);
    endtask

    initial begin
        rst       = 1'b1;
        pt_valid  = 1'b0;
        pt_last   = 1'b0;
        pt_coords = '0;
        out_ready = 1'b0;
        test_reset();
        test_single_point();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_reset_mid_emit();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
